// File: rtl/ctrl_pkg.sv
// Shared control-register definitions: host opcodes, status word bit
// positions and the responder FSM encoding visible to host drivers.
package ctrl_pkg;

  localparam logic [7:0] INST_COMPUTE     = 8'd87;
  localparam logic [7:0] INST_ACK         = 8'd88;
  localparam logic [7:0] INST_READ_OFMAPS = 8'd89;

  localparam int unsigned ST_DONE_BIT    = 0;
  localparam int unsigned ST_BUSY_BIT    = 1;
  localparam int unsigned ST_FULL_BIT    = 2;
  localparam int unsigned ST_STARVED_BIT = 3;
  localparam int unsigned ST_PERR_BIT    = 4;
  localparam int unsigned ST_READOUT_BIT = 5;
  localparam int unsigned ST_STATE_LSB   = 6;
  localparam int unsigned ST_ROW_LSB     = 8;
  localparam int unsigned ST_COL_LSB     = 17;
  localparam int unsigned ST_TAG_LSB     = 26;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DONE    = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_COMPUTE,
    CMD_ACK,
    CMD_READ
  } cmd_t;

  function automatic cmd_t decode_opcode(input logic [7:0] op);
    cmd_t c;
    case (op)
      INST_COMPUTE:     c = CMD_COMPUTE;
      INST_ACK:         c = CMD_ACK;
      INST_READ_OFMAPS: c = CMD_READ;
      default:          c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmd_edge_detect.sv
// Host opcode edge detector: a command fires only on the cycle the opcode
// byte differs from the previous cycle's value.
module cmd_edge_detect
  import ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_opcode,
  output logic       o_fire,
  output cmd_t       o_cmd
);

  logic [7:0] r_prev_opcode;

  // Remember last cycle's opcode so a held command never re-fires
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev_opcode <= '0;
    else       r_prev_opcode <= i_opcode;
  end

  assign o_fire = (i_opcode != r_prev_opcode);
  assign o_cmd  = o_fire ? decode_opcode(i_opcode) : CMD_NONE;

endmodule

// File: rtl/status_responder.sv
// Status responder: tracks job progress from pixel_done pulses and host
// commands, publishes it in axi_control_3, pulses done_irq on completion
// and gates ofmaps readout. Optional busy-cycle counter: STATUS_PERF_CNT_EN.
module status_responder
  import ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT         = 1024,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_0,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_1,
  input  logic                            pixel_done,
  input  logic                            ifmaps_fifo_empty,
  input  logic                            ofmaps_fifo_full,
  input  logic                            ofmaps_fifo_empty,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_3,
  output logic                            done_irq,
  output logic                            readout_en,
  output logic [31:0]                     busy_cycles
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic          w_fire;
  cmd_t          w_cmd;
  logic          w_start;

  state_t        r_state,  w_state_n;
  logic [8:0]    r_row,    w_row_n;
  logic [8:0]    r_col,    w_col_n;
  logic [8:0]    r_dim,    w_dim_n;
  logic [5:0]    r_tag,    w_tag_n;
  logic          r_done,   w_done_n;
  logic          r_starved, w_starved_n;
  logic          r_perr,   w_perr_n;
  logic [SW-1:0] r_starve, w_starve_n;
  logic          r_irq,    w_irq_n;
  logic          r_readout;
  logic          r_full;
  logic [31:0]   w_status;
  logic          w_unused;

  cmd_edge_detect u_cmd_edge (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_opcode (axi_control_0[7:0]),
    .o_fire   (w_fire),
    .o_cmd    (w_cmd)
  );

  // Next-state: starvation, then pixel_done against the current state,
  // then readout drain, then the host command against the resulting state
  always_comb begin
    w_state_n   = r_state;
    w_row_n     = r_row;
    w_col_n     = r_col;
    w_dim_n     = r_dim;
    w_tag_n     = r_tag;
    w_done_n    = r_done;
    w_starved_n = r_starved;
    w_perr_n    = r_perr;
    w_starve_n  = r_starve;
    w_irq_n     = 1'b0;
    w_start     = 1'b0;

    if (r_state == S_BUSY) begin
      if (!ifmaps_fifo_empty)   w_starve_n = '0;
      else if (r_starve != LIMIT) w_starve_n = r_starve + 1'b1;
      if (w_starve_n == LIMIT)  w_starved_n = 1'b1;
    end

    if (pixel_done) begin
      if (r_state == S_BUSY) begin
        if (r_col == r_dim && r_row == r_dim) begin
          w_state_n = S_DONE;
          w_done_n  = 1'b1;
          w_irq_n   = 1'b1;
        end else if (r_col == r_dim) begin
          w_col_n = '0;
          w_row_n = r_row + 9'd1;
        end else begin
          w_col_n = r_col + 9'd1;
        end
      end else begin
        w_perr_n = 1'b1;
      end
    end

    if (r_state == S_READOUT && ofmaps_fifo_empty) begin
      w_state_n = S_IDLE;
      w_done_n  = 1'b0;
    end

    case (w_cmd)
      CMD_COMPUTE: begin
        if (w_state_n == S_IDLE) begin
          w_start     = 1'b1;
          w_state_n   = S_BUSY;
          w_dim_n     = axi_control_1[10:2];
          w_tag_n     = axi_control_0[31:26];
          w_row_n     = '0;
          w_col_n     = '0;
          w_done_n    = 1'b0;
          w_starved_n = 1'b0;
          w_perr_n    = 1'b0;
          w_starve_n  = '0;
        end else begin
          w_perr_n = 1'b1;
        end
      end
      CMD_ACK: begin
        if (w_state_n == S_DONE) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b0;
          w_perr_n  = 1'b0;
        end else if (w_state_n != S_IDLE) begin
          w_perr_n = 1'b1;
        end
      end
      CMD_READ: begin
        if (w_state_n == S_DONE) w_state_n = S_READOUT;
      end
      default: ;
    endcase
  end

  // Job FSM and all registered status fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_dim     <= '0;
      r_tag     <= '0;
      r_done    <= 1'b0;
      r_starved <= 1'b0;
      r_perr    <= 1'b0;
      r_starve  <= '0;
      r_irq     <= 1'b0;
      r_readout <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_row     <= w_row_n;
      r_col     <= w_col_n;
      r_dim     <= w_dim_n;
      r_tag     <= w_tag_n;
      r_done    <= w_done_n;
      r_starved <= w_starved_n;
      r_perr    <= w_perr_n;
      r_starve  <= w_starve_n;
      r_irq     <= w_irq_n;
      r_readout <= (w_state_n == S_READOUT);
      r_full    <= ofmaps_fifo_full;
    end
  end

  // Assemble the host-visible status word from registered fields
  always_comb begin
    w_status                              = '0;
    w_status[ST_DONE_BIT]                 = r_done;
    w_status[ST_BUSY_BIT]                 = (r_state == S_BUSY);
    w_status[ST_FULL_BIT]                 = r_full;
    w_status[ST_STARVED_BIT]              = r_starved;
    w_status[ST_PERR_BIT]                 = r_perr;
    w_status[ST_READOUT_BIT]              = r_readout;
    w_status[ST_STATE_LSB +: 2]           = r_state;
    w_status[ST_ROW_LSB +: 9]             = r_row;
    w_status[ST_COL_LSB +: 9]             = r_col;
    w_status[ST_TAG_LSB +: 6]             = r_tag;
  end

  assign axi_control_3 = w_status;
  assign done_irq      = r_irq;
  assign readout_en    = r_readout;

`ifdef STATUS_PERF_CNT_EN
  logic [31:0] r_busy_cycles;

  // Saturating count of cycles spent in BUSY, restarted by each job start
  always_ff @(posedge clk) begin
    if (rst)                                        r_busy_cycles <= '0;
    else if (w_start)                               r_busy_cycles <= '0;
    else if (r_state == S_BUSY && r_busy_cycles != '1) r_busy_cycles <= r_busy_cycles + 32'd1;
  end

  assign busy_cycles = r_busy_cycles;
  assign w_unused = ^{axi_control_0[25:8], axi_control_1[31:11], axi_control_1[1:0]};
`else
  assign busy_cycles = '0;
  assign w_unused = ^{axi_control_0[25:8], axi_control_1[31:11], axi_control_1[1:0], w_start};
`endif

endmodule
